mac_seq_ctrl: RTL and testbench

- Sequences the existing combinational 16x16 unsigned multiplier `Vedic_Mult16` (ports a, b, out[31:0]) as a vector multiply-accumulate engine.
- Operation: accepts a vector length on `start`, consumes that many operand pairs over a valid/ready stream, and accumulates the products.
- Presents the dot-product result on a valid/ready output.
- This is the top-level control of the MAC unit.

---
 rtl/mac_pkg.sv | 15 +
 rtl/Vedic_Mult16.sv | 11 +
 rtl/mac_acc_sat.sv | 28 ++
 rtl/mac_seq_ctrl.sv | 115 +++++++++++
 tb/tb_mac_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the sequenced multiply-accumulate unit.
// The MAC_SEQ_SAT_EN build option lives only in mac_acc_sat.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mac_state_t;

    localparam int MAC_ACC_W = 40;
    localparam int MAC_LEN_W = 8;
    localparam int MAC_OP_W  = 16;

endpackage

// File: rtl/Vedic_Mult16.sv
// Behavioural stand-in for the existing combinational 16x16 unsigned multiplier.
// Port names match the original block so it can be swapped in unchanged.
module Vedic_Mult16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] out
);

    assign out = a * b;

endmodule

// File: rtl/mac_acc_sat.sv
// Accumulator adder with carry detect and wrap/saturate result select.
// Build option: define MAC_SEQ_SAT_EN to clamp the sum to all ones on carry-out.
module mac_acc_sat
    import mac_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W,
    parameter int OP_W  = MAC_OP_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [2*OP_W-1:0] prod_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              carry_o
);

    logic [ACC_W:0] sum;

    // One extra bit on the adder captures the carry out of the accumulator MSB.
    assign sum     = {1'b0, acc_i} + {{(ACC_W + 1 - 2*OP_W){1'b0}}, prod_i};
    assign carry_o = sum[ACC_W];

`ifdef MAC_SEQ_SAT_EN
    // Once clamped, any further nonzero product carries again, so the sum stays pinned.
    assign acc_o = carry_o ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_o = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_seq_ctrl.sv
// Top-level control of the MAC unit: streams operand pairs through Vedic_Mult16 and
// accumulates a dot product. Wrap vs. saturate is selected by MAC_SEQ_SAT_EN (see mac_acc_sat).
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W,
    parameter int LEN_W = MAC_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    vec_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAC_OP_W-1:0] in_a,
    input  logic [MAC_OP_W-1:0] in_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic                busy,
    output logic                overflow
);

    mac_state_t             state_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_d;
    logic [LEN_W-1:0]       count_q;
    logic                   ovf_q;
    logic                   in_ready_q;
    logic                   res_valid_q;
    logic                   busy_q;
    logic [2*MAC_OP_W-1:0]  prod;
    logic                   carry;

    Vedic_Mult16 u_mult (
        .a   (in_a),
        .b   (in_b),
        .out (prod)
    );

    mac_acc_sat #(
        .ACC_W (ACC_W),
        .OP_W  (MAC_OP_W)
    ) u_acc (
        .acc_i   (acc_q),
        .prod_i  (prod),
        .acc_o   (acc_d),
        .carry_o (carry)
    );

    // Handshake flags are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (vec_len != '0) begin
                            count_q    <= vec_len;
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid && in_ready_q) begin
                        acc_q   <= acc_d;
                        count_q <= count_q - LEN_W'(1);
                        if (carry) begin
                            ovf_q <= 1'b1;
                        end
                        if (count_q == LEN_W'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign res_data  = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: a default 40-bit instance and a 32-bit instance
// share one stimulus stream; expected results come from a vector table through a queue.
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        res_ready;

    logic        inReady40, resValid40, busy40, ovf40;
    logic [39:0] resData40;
    logic        inReady32, resValid32, busy32, ovf32;
    logic [31:0] resData32;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        int               len;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        int               gap;
        int               rrDelay;
        bit               pulseStart;
        logic [39:0]      exp40;
        logic [31:0]      exp32;
        bit               ovf32;
    } vec_t;

    typedef struct {
        logic [39:0] d40;
        logic [31:0] d32;
        bit          o32;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    mac_seq_ctrl dut40 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (inReady40),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (resValid40),
        .res_ready (res_ready),
        .res_data  (resData40),
        .busy      (busy40),
        .overflow  (ovf40)
    );

    mac_seq_ctrl #(.ACC_W(32), .LEN_W(8)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (inReady32),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (resValid32),
        .res_ready (res_ready),
        .res_data  (resData32),
        .busy      (busy32),
        .overflow  (ovf32)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one table vector; inputs change on the falling edge, outputs are sampled there too.
    task automatic applyStimulus(input int idx);
        vec_t        v;
        exp_t        e;
        logic [39:0] held;
        int          k;
        v     = vecs[idx];
        e.d40 = v.exp40;
        e.d32 = v.exp32;
        e.o32 = v.ovf32;
        sbq.push_back(e);

        start   = 1'b1;
        vec_len = v.len[7:0];
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy after start", {63'd0, busy40}, 64'd1);

        for (int i = 0; i < v.len; i++) begin
            in_valid = 1'b0;
            repeat (v.gap) @(negedge clk);
            checkOutput("in_ready in RUN", {63'd0, inReady40}, 64'd1);
            in_valid = 1'b1;
            in_a     = v.a[i];
            in_b     = v.b[i];
            if (v.pulseStart && i == 0) begin
                start   = 1'b1;
                vec_len = 8'd7;
            end
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
        end

        checkOutput("res_valid latency", {63'd0, resValid40}, 64'd1);
        k = 0;
        while (!resValid40 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("res_valid wait", {63'd0, resValid40}, 64'd1);

        held = resData40;
        for (int r = 0; r < v.rrDelay; r++) begin
            if (v.pulseStart && r == 0) begin
                start   = 1'b1;
                vec_len = 8'd5;
            end
            @(negedge clk);
            start = 1'b0;
            checkOutput("in_ready in DONE", {63'd0, inReady40}, 64'd0);
            checkOutput("res_valid held", {63'd0, resValid40}, 64'd1);
            checkOutput("res_data stable", {24'd0, resData40}, {24'd0, held});
        end

        e = sbq.pop_front();
        checkOutput("res_data acc40", {24'd0, resData40}, {24'd0, e.d40});
        checkOutput("overflow acc40", {63'd0, ovf40}, 64'd0);
        checkOutput("res_valid acc32", {63'd0, resValid32}, 64'd1);
        checkOutput("res_data acc32", {32'd0, resData32}, {32'd0, e.d32});
        checkOutput("overflow acc32", {63'd0, ovf32}, {63'd0, e.o32});

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("res_valid after handshake", {63'd0, resValid40}, 64'd0);
        checkOutput("busy after handshake", {63'd0, busy40}, 64'd0);
    endtask

    task automatic midRunReset();
        start   = 1'b1;
        vec_len = 8'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 16'd5;
        in_b     = 16'd5;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("acc before reset", {24'd0, resData40}, 64'd25);
        rst = 1'b1;
        #1;
        checkOutput("reset in_ready", {63'd0, inReady40}, 64'd0);
        checkOutput("reset busy", {63'd0, busy40}, 64'd0);
        checkOutput("reset res_valid", {63'd0, resValid40}, 64'd0);
        checkOutput("reset res_data", {24'd0, resData40}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset busy", {63'd0, busy40}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{len: 3, a: '0, b: '0, gap: 0, rrDelay: 0, pulseStart: 0,
                    exp40: 40'd56089, exp32: 32'd56089, ovf32: 0};
        vecs[0].a[0] = 16'd1;   vecs[0].b[0] = 16'd1;
        vecs[0].a[1] = 16'd123; vecs[0].b[1] = 16'd456;

        vecs[1] = '{len: 2, a: '0, b: '0, gap: 0, rrDelay: 0, pulseStart: 0,
                    exp40: 40'd8589672450, exp32: 32'd4294705154, ovf32: 1};
`ifdef MAC_SEQ_SAT_EN
        vecs[1].exp32 = 32'd4294967295;
`endif
        vecs[1].a[0] = 16'hFFFF; vecs[1].b[0] = 16'hFFFF;
        vecs[1].a[1] = 16'hFFFF; vecs[1].b[1] = 16'hFFFF;

        vecs[2] = '{len: 0, a: '0, b: '0, gap: 0, rrDelay: 1, pulseStart: 0,
                    exp40: 40'd0, exp32: 32'd0, ovf32: 0};

        vecs[3] = '{len: 4, a: '0, b: '0, gap: 2, rrDelay: 5, pulseStart: 0,
                    exp40: 40'd185798, exp32: 32'd185798, ovf32: 0};
        vecs[3].a[0] = 16'd10;    vecs[3].b[0] = 16'd20;
        vecs[3].a[1] = 16'd300;   vecs[3].b[1] = 16'd400;
        vecs[3].a[2] = 16'hFFFF;  vecs[3].b[2] = 16'd1;
        vecs[3].a[3] = 16'd7;     vecs[3].b[3] = 16'd9;

        vecs[4] = '{len: 1, a: '0, b: '0, gap: 0, rrDelay: 2, pulseStart: 1,
                    exp40: 40'd6, exp32: 32'd6, ovf32: 0};
        vecs[4].a[0] = 16'd2; vecs[4].b[0] = 16'd3;

        vecs[5] = '{len: 3, a: '0, b: '0, gap: 1, rrDelay: 1, pulseStart: 1,
                    exp40: 40'd8589672451, exp32: 32'd4294705155, ovf32: 1};
`ifdef MAC_SEQ_SAT_EN
        vecs[5].exp32 = 32'd4294967295;
`endif
        vecs[5].a[0] = 16'hFFFF; vecs[5].b[0] = 16'hFFFF;
        vecs[5].a[1] = 16'hFFFF; vecs[5].b[1] = 16'hFFFF;
        vecs[5].a[2] = 16'd1;    vecs[5].b[2] = 16'd1;

        rst       = 1'b1;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("init in_ready", {63'd0, inReady40}, 64'd0);
        checkOutput("init res_valid", {63'd0, resValid40}, 64'd0);
        checkOutput("init busy", {63'd0, busy40}, 64'd0);
        checkOutput("init res_data", {24'd0, resData40}, 64'd0);
        checkOutput("init overflow", {63'd0, ovf40}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0);
        midRunReset();
        for (int i = 1; i < 6; i++) begin
            applyStimulus(i);
        end

        checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
